// File: rtl/add_operand_feeder_pkg.sv
// Types and defaults shared by the operand feeder and the 4-bit `add` benches.
package add_operand_feeder_pkg;

   localparam int unsigned ADD_WIDTH = 4;

   typedef struct packed {
      logic [ADD_WIDTH-1:0] a;
      logic [ADD_WIDTH-1:0] b;
   } pair_t;

endpackage

// File: rtl/add_operand_feeder_sync_fifo.sv
// Synchronous FIFO with an occupancy output. There is no bypass path, so a push into an
// empty FIFO is only visible at the head after the edge.
module add_operand_feeder_sync_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic [PW:0]   level
);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0]   level_q;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else if (clear) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         if (push && !pop) begin
            level_q <= level_q + 1'b1;
         end else if (pop && !push) begin
            level_q <= level_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wptr_q] <= wdata;
   end

   assign rdata = mem[rptr_q];
   assign level = level_q;

endmodule

// File: rtl/add_operand_feeder.sv
// Buffers operand pairs for the external adder, registers its sum/carry as a result stream
// and counts carry-out events.
module add_operand_feeder
   import add_operand_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = ADD_WIDTH,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic [WIDTH-1:0]         num1,
   output logic [WIDTH-1:0]         num2,
   input  logic [WIDTH-1:0]         sum_in,
   input  logic                     cout_in,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_sum,
   output logic                     res_cout,
   output logic [CNT_W-1:0]         ovf_count,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [CNT_W-1:0] OVF_MAX = '1;

   logic              push, pop, not_empty;
   logic [2*WIDTH-1:0] head;
   logic [LW-1:0]     level;

   logic              res_valid_q;
   logic [WIDTH-1:0]  res_sum_q;
   logic              res_cout_q;
   logic [CNT_W-1:0]  ovf_q;

   add_operand_feeder_sync_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata ({in_a, in_b}),
      .rdata (head),
      .level (level)
   );

   // in_ready ignores a same-edge pop and clear, so a full FIFO never accepts.
   assign in_ready  = (level != FULL_LEVEL);
   assign not_empty = (level != '0);
   assign push      = in_valid & in_ready & ~clear;
   assign pop       = not_empty & (~res_valid_q | res_ready) & ~clear;

   assign num1 = not_empty ? head[2*WIDTH-1:WIDTH] : '0;
   assign num2 = not_empty ? head[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_cout_q  <= 1'b0;
         ovf_q       <= '0;
      end else if (clear) begin
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_cout_q  <= 1'b0;
         ovf_q       <= '0;
      end else if (pop) begin
         res_valid_q <= 1'b1;
         res_sum_q   <= sum_in;
         res_cout_q  <= cout_in;
         if (cout_in && (ovf_q != OVF_MAX)) ovf_q <= ovf_q + 1'b1;
      end else if (res_ready) begin
         res_valid_q <= 1'b0;
      end
   end

   assign res_valid  = res_valid_q;
   assign res_sum    = res_sum_q;
   assign res_cout   = res_cout_q;
   assign ovf_count  = ovf_q;
   assign fifo_level = level;

endmodule

// File: tb/tb_add_operand_feeder.sv
// Directed bench: two feeders (CNT_W 8 and 2) share stimulus, each with a behavioural adder.
module tb_add_operand_feeder;
   import add_operand_feeder_pkg::*;

   typedef struct packed {
      logic [3:0] sum;
      logic       cout;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n, clear, in_valid, res_ready;
   logic [3:0] in_a, in_b;

   logic       in_ready, cout_in, res_valid, res_cout;
   logic [3:0] num1, num2, sum_in, res_sum;
   logic [7:0] ovf_count;
   logic [2:0] fifo_level;

   logic       s_in_ready, s_cout_in, s_res_valid, s_res_cout;
   logic [3:0] s_num1, s_num2, s_sum_in, s_res_sum;
   logic [1:0] s_ovf_count;
   logic [2:0] s_fifo_level;

   int   total = 0;
   int   bad = 0;
   int   exp_ovf = 0;
   int   nacc;
   bit   acc;
   res_t sb[$];
   res_t r;

   add_operand_feeder #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .num1(num1), .num2(num2), .sum_in(sum_in),
      .cout_in(cout_in), .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
      .res_cout(res_cout), .ovf_count(ovf_count), .fifo_level(fifo_level)
   );

   add_operand_feeder #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_a(in_a), .in_b(in_b), .num1(s_num1), .num2(s_num2), .sum_in(s_sum_in),
      .cout_in(s_cout_in), .res_valid(s_res_valid), .res_ready(res_ready),
      .res_sum(s_res_sum), .res_cout(s_res_cout), .ovf_count(s_ovf_count),
      .fifo_level(s_fifo_level)
   );

   // Behavioural stand-ins for the 4-bit ripple adders.
   assign {cout_in, sum_in}     = {1'b0, num1} + {1'b0, num2};
   assign {s_cout_in, s_sum_in} = {1'b0, s_num1} + {1'b0, s_num2};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one pair for one cycle; on acceptance push its expected result.
   task automatic offer(input logic [3:0] a, input logic [3:0] b, output bit accepted);
      pair_t p;
      logic [4:0] full;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      @(negedge clk);
      accepted = in_ready && !clear;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (accepted) begin
         p.a = a;
         p.b = b;
         full = {1'b0, p.a} + {1'b0, p.b};
         sb.push_back('{sum: full[3:0], cout: full[4]});
         if (full[4]) exp_ovf++;
      end
   endtask

   // Result monitor: a transfer happens at the next edge when valid & ready are both high.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         check("sb_avail", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            r = sb.pop_front();
            check("res_sum", 32'(res_sum), 32'(r.sum));
            check("res_cout", 32'(res_cout), 32'(r.cout));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      in_valid = 1'b0;
      res_ready = 1'b0;
      in_a = '0;
      in_b = '0;
      #12;
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_ovf", 32'(ovf_count), 32'd0);
      check("rst_num1", 32'(num1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // 3+4: result one cycle after acceptance
      res_ready = 1'b1;
      offer(4'd3, 4'd4, acc);
      check("t1_acc", 32'(acc), 32'd1);
      check("t1_num1", 32'(num1), 32'd3);
      check("t1_num2", 32'(num2), 32'd4);
      check("t1_level", 32'(fifo_level), 32'd1);
      check("t1_valid_early", 32'(res_valid), 32'd0);
      @(posedge clk);
      #1;
      check("t1_valid", 32'(res_valid), 32'd1);
      check("t1_sum", 32'(res_sum), 32'd7);
      check("t1_cout", 32'(res_cout), 32'd0);
      check("t1_ovf", 32'(ovf_count), 32'd0);

      // 15+1 then 9+8: two carries
      offer(4'd15, 4'd1, acc);
      offer(4'd9, 4'd8, acc);
      repeat (3) @(posedge clk);
      #1;
      check("t2_ovf", 32'(ovf_count), 32'd2);
      check("t2_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure: six offers, five fit
      res_ready = 1'b0;
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         offer(4'(i * 3 + 2), 4'(i + 11), acc);
         if (acc) nacc++;
      end
      check("bp_accepted", 32'(nacc), 32'd5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_level", 32'(fifo_level), 32'd4);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_drain_valid", 32'(res_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      check("bp_drained_valid", 32'(res_valid), 32'd0);
      check("bp_sb_empty", 32'(sb.size()), 32'd0);
      check("bp_ovf", 32'(ovf_count), 32'(exp_ovf));

      // Full FIFO with a pop on the same edge: no accept
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) offer(4'(i + 1), 4'(2 * i), acc);
      check("fp_level_full", 32'(fifo_level), 32'd4);
      in_valid = 1'b1;
      in_a = 4'd7;
      in_b = 4'd7;
      res_ready = 1'b1;
      @(negedge clk);
      check("fp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("fp_level", 32'(fifo_level), 32'd3);
      check("fp_in_ready_after", 32'(in_ready), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      check("fp_sb_empty", 32'(sb.size()), 32'd0);
      check("fp_res_valid", 32'(res_valid), 32'd0);

      // clear with three queued and a held result
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) offer(4'(i + 9), 4'(i + 9), acc);
      check("cl_level", 32'(fifo_level), 32'd3);
      check("cl_res_valid", 32'(res_valid), 32'd1);
      clear = 1'b1;
      in_valid = 1'b1;
      in_a = 4'd5;
      in_b = 4'd5;
      @(negedge clk);
      check("cl_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      clear = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      exp_ovf = 0;
      check("cl_level_after", 32'(fifo_level), 32'd0);
      check("cl_valid_after", 32'(res_valid), 32'd0);
      check("cl_ovf_after", 32'(ovf_count), 32'd0);
      check("cl_num1", 32'(num1), 32'd0);
      check("cl_num2", 32'(num2), 32'd0);
      @(posedge clk);
      #1;
      check("cl_dropped", 32'(fifo_level), 32'd0);

      // Saturation: 2-bit counter stops at 3
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) offer(4'd8, 4'd8, acc);
      repeat (3) @(posedge clk);
      #1;
      check("sat_small", 32'(s_ovf_count), 32'd3);
      check("sat_wide", 32'(ovf_count), 32'(exp_ovf));
      check("sat_sb_empty", 32'(sb.size()), 32'd0);

      // Asynchronous reset mid-stream
      res_ready = 1'b0;
      offer(4'd3, 4'd3, acc);
      offer(4'd1, 4'd14, acc);
      offer(4'd12, 4'd6, acc);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_res_valid", 32'(res_valid), 32'd0);
      check("ar_res_sum", 32'(res_sum), 32'd0);
      check("ar_level", 32'(fifo_level), 32'd0);
      check("ar_ovf", 32'(ovf_count), 32'd0);
      check("ar_num1", 32'(num1), 32'd0);
      sb.delete();
      exp_ovf = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      offer(4'd2, 4'd2, acc);
      check("ar_restart_acc", 32'(acc), 32'd1);
      @(posedge clk);
      #1;
      check("ar_restart_valid", 32'(res_valid), 32'd1);
      check("ar_restart_sum", 32'(res_sum), 32'd4);
      repeat (2) @(posedge clk);
      #1;
      check("ar_sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
